mem_reinit_ctrl: RTL and testbench



---
 rtl/mem_reinit_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_reinit_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_reinit_ctrl.sv
// Sweep sequencer and sole port owner for one simple-dual-port RAM: fills the
// array with a pattern, reads it back, and counts mismatches; idle passes the user port.
module mem_reinit_ctrl #(
  parameter int WID_MEM   = 2,
  parameter int DEPTH_MEM = 16384,
  parameter int ERR_W     = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_verify_only,
  input  logic [WID_MEM-1:0] i_fill_val,
  output logic               o_busy,
  output logic               o_done,
  output logic [ERR_W-1:0]   o_err_count,
  output logic               o_err_valid,
  output logic [31:0]        o_first_err_addr,
  input  logic               i_user_we,
  input  logic [31:0]        i_user_waddr,
  input  logic [31:0]        i_user_raddr,
  input  logic [WID_MEM-1:0] i_user_din,
  output logic [WID_MEM-1:0] o_user_dout,
  output logic               o_user_stall,
  output logic [31:0]        o_mem_raddr,
  output logic [31:0]        o_mem_waddr,
  output logic [WID_MEM-1:0] o_mem_din,
  output logic               o_mem_we,
  input  logic [WID_MEM-1:0] i_mem_dout,
  output logic [2:0]         o_dbg_state
);

  localparam int ADDR_W = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [WID_MEM-1:0] r_pat;
  logic               r_cmp_vld;
  logic [ADDR_W-1:0]  r_cmp_addr;
  logic               r_busy;
  logic               r_done;
  logic [ERR_W-1:0]   r_err_count;
  logic               r_err_valid;
  logic [31:0]        r_first_err_addr;

  logic [31:0]        w_addr_ext;
  logic               w_mismatch;

  assign w_addr_ext = 32'(r_addr);
  // r_cmp_vld marks the cycle in which i_mem_dout holds the word read at r_cmp_addr.
  assign w_mismatch = r_cmp_vld && (i_mem_dout != r_pat);

  // Start/busy handshake: i_start is a level request sampled only in IDLE; it is
  // accepted on that edge, o_busy rises the next cycle and drops when DONE is entered.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state          <= ST_IDLE;
      r_addr           <= '0;
      r_pat            <= '0;
      r_cmp_vld        <= 1'b0;
      r_cmp_addr       <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err_count      <= '0;
      r_err_valid      <= 1'b0;
      r_first_err_addr <= '0;
    end else begin
      r_done     <= 1'b0;
      r_cmp_vld  <= 1'b0;
      r_cmp_addr <= r_addr;

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_pat            <= i_fill_val;
            r_addr           <= '0;
            r_err_count      <= '0;
            r_err_valid      <= 1'b0;
            r_first_err_addr <= '0;
            r_busy           <= 1'b1;
            r_state          <= i_verify_only ? ST_VERIFY : ST_FILL;
          end
        end
        ST_FILL: begin
          if (r_addr == LAST_ADDR) begin
            r_addr  <= '0;
            r_state <= ST_VERIFY;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        ST_VERIFY: begin
          r_cmp_vld <= 1'b1;
          if (r_addr == LAST_ADDR) begin
            r_addr  <= '0;
            r_state <= ST_DRAIN;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase

      if (w_mismatch) begin
        if (r_err_count != ERR_MAX) begin
          r_err_count <= r_err_count + ERR_W'(1);
        end
        if (!r_err_valid) begin
          r_err_valid      <= 1'b1;
          r_first_err_addr <= 32'(r_cmp_addr);
        end
      end
    end
  end

  // IDLE and DONE hand the RAM to the user; every sweep state owns it outright.
  always_comb begin
    o_mem_we    = i_user_we;
    o_mem_waddr = i_user_waddr;
    o_mem_raddr = i_user_raddr;
    o_mem_din   = i_user_din;
    case (r_state)
      ST_FILL: begin
        o_mem_we    = 1'b1;
        o_mem_waddr = w_addr_ext;
        o_mem_raddr = w_addr_ext;
        o_mem_din   = r_pat;
      end
      ST_VERIFY, ST_DRAIN: begin
        o_mem_we    = 1'b0;
        o_mem_waddr = w_addr_ext;
        o_mem_raddr = w_addr_ext;
        o_mem_din   = r_pat;
      end
      default: begin
        o_mem_we    = i_user_we;
        o_mem_waddr = i_user_waddr;
        o_mem_raddr = i_user_raddr;
        o_mem_din   = i_user_din;
      end
    endcase
  end

  assign o_busy           = r_busy;
  assign o_user_stall     = r_busy;
  assign o_done           = r_done;
  assign o_err_count      = r_err_count;
  assign o_err_valid      = r_err_valid;
  assign o_first_err_addr = r_first_err_addr;
  assign o_user_dout      = i_mem_dout;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_mem_reinit_ctrl.sv
// Bench for mem_reinit_ctrl: a 16-word RAM model, a table of sweep scenarios,
// and hand sequences for stalls, ignored starts, DONE-cycle writes and reset.
module tb_mem_reinit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        verify_only;
  logic [1:0]  fill_val;
  logic        user_we;
  logic [31:0] user_waddr;
  logic [31:0] user_raddr;
  logic [1:0]  user_din;
  logic [1:0]  mem_dout;

  logic        a_busy, a_done, a_err_valid, a_stall, a_mem_we;
  logic [31:0] a_err_count, a_first, a_mem_raddr, a_mem_waddr;
  logic [1:0]  a_user_dout, a_mem_din;
  logic [2:0]  a_dbg;

  logic        b_busy, b_done, b_err_valid, b_stall, b_mem_we;
  logic [2:0]  b_err_count;
  logic [31:0] b_first, b_mem_raddr, b_mem_waddr;
  logic [1:0]  b_user_dout, b_mem_din;
  logic [2:0]  b_dbg;

  always #5 clk = ~clk;

  mem_reinit_ctrl #(.WID_MEM(2), .DEPTH_MEM(16), .ERR_W(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_verify_only(verify_only),
    .i_fill_val(fill_val), .o_busy(a_busy), .o_done(a_done), .o_err_count(a_err_count),
    .o_err_valid(a_err_valid), .o_first_err_addr(a_first), .i_user_we(user_we),
    .i_user_waddr(user_waddr), .i_user_raddr(user_raddr), .i_user_din(user_din),
    .o_user_dout(a_user_dout), .o_user_stall(a_stall), .o_mem_raddr(a_mem_raddr),
    .o_mem_waddr(a_mem_waddr), .o_mem_din(a_mem_din), .o_mem_we(a_mem_we),
    .i_mem_dout(mem_dout), .o_dbg_state(a_dbg)
  );

  // Narrow-counter twin: same stimulus and read data, only the count width differs.
  mem_reinit_ctrl #(.WID_MEM(2), .DEPTH_MEM(16), .ERR_W(3)) dut_sat (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_verify_only(verify_only),
    .i_fill_val(fill_val), .o_busy(b_busy), .o_done(b_done), .o_err_count(b_err_count),
    .o_err_valid(b_err_valid), .o_first_err_addr(b_first), .i_user_we(user_we),
    .i_user_waddr(user_waddr), .i_user_raddr(user_raddr), .i_user_din(user_din),
    .o_user_dout(b_user_dout), .o_user_stall(b_stall), .o_mem_raddr(b_mem_raddr),
    .o_mem_waddr(b_mem_waddr), .o_mem_din(b_mem_din), .o_mem_we(b_mem_we),
    .i_mem_dout(mem_dout), .o_dbg_state(b_dbg)
  );

  logic [1:0] ram [16];
  always @(posedge clk) begin
    if (a_mem_we && a_mem_waddr < 32'd16) ram[a_mem_waddr[3:0]] <= a_mem_din;
    mem_dout <= (a_mem_raddr < 32'd16) ? ram[a_mem_raddr[3:0]] : 2'b00;
  end

  int lock_bad = 0;
  always @(negedge clk) begin
    if ({b_busy, b_done, b_err_valid, b_first, b_user_dout, b_stall, b_mem_raddr,
         b_mem_waddr, b_mem_din, b_mem_we, b_dbg} !==
        {a_busy, a_done, a_err_valid, a_first, a_user_dout, a_stall, a_mem_raddr,
         a_mem_waddr, a_mem_din, a_mem_we, a_dbg})
      lock_bad++;
  end

  typedef struct {
    bit          do_pre;
    logic [1:0]  pre_val;
    logic [15:0] mask;
    logic [1:0]  bad_val;
    logic        vo;
    logic [1:0]  fv;
    int          lat;
    logic [31:0] cnt;
    logic [31:0] first;
    logic        vld;
    logic [2:0]  cnt_b;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] cnt;
    logic [31:0] first;
    logic        vld;
    logic [2:0]  cnt_b;
  } sweep_t;

  vec_t       vecs [7];
  sweep_t     exp_sw_q [$];
  logic [1:0] exp_q [$];
  logic [1:0] shadow [16];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic user_write(input int addr, input logic [1:0] d);
    @(negedge clk);
    user_we = 1'b1; user_waddr = 32'(addr); user_din = d;
    @(negedge clk);
    user_we = 1'b0;
    shadow[addr] = d;
  endtask

  task automatic user_read(input int addr);
    logic [1:0] e;
    @(negedge clk);
    user_raddr = 32'(addr);
    exp_q.push_back(shadow[addr]);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("rd_data[%0d]", addr), 32'(a_user_dout), 32'(e));
  endtask

  task automatic run_sweep(input logic vo, input logic [1:0] fv, input int lat,
                           input logic [31:0] cnt, input logic [31:0] first, input logic vld,
                           input logic [2:0] cnt_b, input bit extra_start,
                           input bit fill_poke, input bit done_poke);
    sweep_t e;
    sweep_t g;
    int     n;
    bit     seen;
    e.lat = lat; e.cnt = cnt; e.first = first; e.vld = vld; e.cnt_b = cnt_b;
    exp_sw_q.push_back(e);
    @(negedge clk);
    start = 1'b1; verify_only = vo; fill_val = fv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(a_busy), 32'd1);
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      start = extra_start && (n == 9);
      if (fill_poke && n == 3) begin
        user_we = 1'b1; user_waddr = 32'd7; user_din = 2'b11;
        #1;
        check("fill_owns_we", 32'(a_mem_we), 32'd1);
        check("fill_owns_din", 32'(a_mem_din), 32'(fv));
        check("fill_owns_waddr", a_mem_waddr, 32'd3);
        check("fill_stall", 32'(a_stall), 32'd1);
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      user_we = 1'b0; start = 1'b0;
      if (a_done) seen = 1'b1;
    end
    g = exp_sw_q.pop_front();
    check("done_seen", 32'(seen), 32'd1);
    check("done_latency", 32'(n + 1), 32'(g.lat));
    check("err_count", a_err_count, g.cnt);
    check("first_err_addr", a_first, g.first);
    check("err_valid", 32'(a_err_valid), 32'(g.vld));
    check("err_count_sat", 32'(b_err_count), 32'(g.cnt_b));
    check("busy_in_done", 32'(a_busy), 32'd0);
    if (!vo) for (int i = 0; i < 16; i++) shadow[i] = fv;
    if (done_poke) begin
      user_we = 1'b1; user_waddr = 32'd2; user_din = ~fv;
      #1;
      check("done_we_pass", 32'(a_mem_we), 32'd1);
      check("done_waddr_pass", a_mem_waddr, 32'd2);
      check("done_stall", 32'(a_stall), 32'd0);
      shadow[2] = ~fv;
    end
    @(negedge clk);
    user_we = 1'b0;
    check("done_one_cycle", 32'(a_done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    vecs[0] = '{1'b0, 2'b00, 16'h0000, 2'b00, 1'b0, 2'b10, 34, 32'd0,  32'd0, 1'b0, 3'd0};
    vecs[1] = '{1'b1, 2'b10, 16'h0020, 2'b01, 1'b1, 2'b10, 18, 32'd1,  32'd5, 1'b1, 3'd1};
    vecs[2] = '{1'b1, 2'b10, 16'h8208, 2'b00, 1'b1, 2'b10, 18, 32'd3,  32'd3, 1'b1, 3'd3};
    vecs[3] = '{1'b1, 2'b00, 16'h0000, 2'b00, 1'b1, 2'b11, 18, 32'd16, 32'd0, 1'b1, 3'd7};
    vecs[4] = '{1'b0, 2'b00, 16'h0000, 2'b00, 1'b0, 2'b01, 34, 32'd0,  32'd0, 1'b0, 3'd0};
    vecs[5] = '{1'b1, 2'b11, 16'h8001, 2'b10, 1'b1, 2'b11, 18, 32'd2,  32'd0, 1'b1, 3'd2};
    vecs[6] = '{1'b1, 2'b01, 16'hFFFE, 2'b00, 1'b1, 2'b01, 18, 32'd15, 32'd1, 1'b1, 3'd7};

    reset = 1'b1; start = 1'b0; verify_only = 1'b0; fill_val = 2'b00;
    user_we = 1'b1; user_waddr = 32'd0; user_raddr = 32'd0; user_din = 2'b00;
    #2;
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_err_count", a_err_count, 32'd0);
    check("rst_err_valid", 32'(a_err_valid), 32'd0);
    check("rst_first", a_first, 32'd0);
    check("rst_state", 32'(a_dbg), 32'd0);
    check("rst_we_follow1", 32'(a_mem_we), 32'd1);
    user_we = 1'b0;
    #1;
    check("rst_we_follow0", 32'(a_mem_we), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].do_pre)
        run_sweep(1'b0, vecs[v].pre_val, 34, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      for (int a = 0; a < 16; a++)
        if (vecs[v].mask[a]) user_write(a, vecs[v].bad_val);
      run_sweep(vecs[v].vo, vecs[v].fv, vecs[v].lat, vecs[v].cnt, vecs[v].first,
                vecs[v].vld, vecs[v].cnt_b, 1'b0, 1'b0, 1'b0);
      user_read(0);
      user_read(5);
      user_read(15);
    end

    // User write during FILL is dropped, an extra start is ignored, DONE passes a write.
    run_sweep(1'b0, 2'b10, 34, 32'd0, 32'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
    user_read(7);
    user_read(2);
    user_write(7, 2'b11);
    user_read(7);

    // Reset in the middle of a fill sweep.
    @(negedge clk);
    start = 1'b1; verify_only = 1'b0; fill_val = 2'b01;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(a_busy), 32'd0);
    check("midrst_state", 32'(a_dbg), 32'd0);
    check("midrst_done", 32'(a_done), 32'd0);
    check("midrst_err_count", a_err_count, 32'd0);
    check("midrst_we", 32'(a_mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_idle", 32'(a_dbg), 32'd0);
    check("narrow_twin_lockstep", 32'(lock_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
